adt7301_sched: RTL and testbench
================================

Name: adt7301_sched

Overview:
- Read scheduler and result handler for the ADT7301 temperature SPI core.
- Issues the single-cycle read request to the core, either periodically or when the host asks for one.
- Accepts the core's 16-bit AXI-stream result, range-checks it, sign-extends the 14-bit two's-complement temperature, and maintains an over-temperature alarm with hysteresis.
- Also handles the case where the core never answers (timeout).

Parameters:
- PERIOD_CYC, 12_500_000, cycles between automatic read requests (100 ms at 125 MHz); must be >= 4.
- TIMEOUT_CYC, 4096, maximum cycles from request to core result before timeout; must be >= 2.
- ALARM_HI, 14'sd2720, alarm set threshold, signed 14-bit, 0.03125 °C/LSB (85 °C).
- ALARM_LO, 14'sd2560, alarm clear threshold (80 °C); must be <= ALARM_HI.

Ports:
- clk  in  1  system clock (125 MHz)
- rst  in  1  synchronous active-high reset
- enable  in  1  1 = scheduler running
- req  in  1  single-cycle host request for an immediate read
- err_clr  in  1  clears timeout_err and fmt_err
- read_temp_flag  out  1  single-cycle read request to the SPI core
- core_tvalid  in  1  core result valid
- core_tready  out  1  ready toward the core
- core_tdata  in  16  raw ADT7301 word
- temp_valid  out  1  single-cycle strobe: new temperature on temp_data
- temp_data  out  16  signed temperature, sign-extended from bits [13:0]
- alarm  out  1  over-temperature alarm (hysteresis)
- busy  out  1  transaction outstanding
- timeout_err  out  1  sticky: core did not answer within TIMEOUT_CYC
- fmt_err  out  1  sticky: received word had bits [15:14] != 2'b00

Behaviour:
Reset state:
- All outputs are 0; state = IDLE; counters are 0; pending request cleared.

State machine, IDLE -> WAIT -> TRIG -> BUSY -> WAIT:
- IDLE: core_tready = 1. Any core beat is accepted and discarded. When enable = 1, go to TRIG on the next cycle, so the first read happens immediately.
- WAIT: the period counter counts up from 0.
  - Reaching PERIOD_CYC-1, or req = 1, or pending = 1 -> go to TRIG, clear pending, reset the counter.
  - enable = 0 -> go to IDLE (takes priority over req).
- TRIG: read_temp_flag = 1 for exactly this cycle. Next state is BUSY with timeout counter = 0.
- BUSY: busy = 1.
  - On a core_tvalid & core_tready beat, process the word and go to WAIT (or IDLE if enable = 0).
  - If no beat arrives and the timeout counter reaches TIMEOUT_CYC-1: set timeout_err, emit no temp_valid, and go to WAIT/IDLE as above.
  - A transaction in flight is never aborted, including when enable drops.
- The period counter runs in TRIG and BUSY as well, so the period measures trigger-to-trigger. If it expires while BUSY, the next trigger fires on entry to WAIT.

Handshake:
- core_tready = 1 in every state after reset (registered; 0 only during reset).
- A beat outside BUSY (for example a late reply after a timeout) is consumed and dropped. It produces no temp_valid and no error.

Host request:
- req during TRIG/BUSY sets pending (one deep). Further req pulses while pending is set are absorbed.
- req during IDLE is ignored.

Word processing, on the beat cycle, registered:
- core_tdata[15:14] != 0: set fmt_err; temp_data, temp_valid and alarm are unchanged.
- Otherwise, on the next cycle:
  - temp_data = {{2{d[13]}}, d[13:0]} and temp_valid = 1 for one cycle.
  - alarm is set if the value >= ALARM_HI (signed compare), cleared if <= ALARM_LO, otherwise held.
- Latency: core beat -> temp_valid is 1 cycle. TRIG entry -> read_temp_flag is 0 cycles (Moore output).

Error flags:
- err_clr clears both error flags.
- If a set event and err_clr happen in the same cycle, the set wins.

Reset mid-operation:
- Everything returns to the reset state the next cycle.
- A core reply that arrives afterward is dropped, because the block is in IDLE.

Decomposition:
- Package adt7301_pkg holds:
  - the state encoding (IDLE, WAIT, TRIG, BUSY);
  - TEMP_W = 14 and RAW_W = 16;
  - TEMP_LSB_MC = 31.25 millidegrees, for documentation and benches;
  - a function converting the raw word to a sign-extended value.
- One natural sub-module, adt7301_tick_gen: the period counter with sync clear and an expire strobe.
- The FSM, timeout, alarm and error logic stay in the top module.

Test Plan:
1. PERIOD_CYC = 100, TIMEOUT_CYC = 20. Assert enable. The bench core replies 0x0320 five cycles after each read_temp_flag. Required: the first flag one cycle after enable; flags every 100 cycles; each reply gives temp_data = 0x0320 and temp_valid one cycle after the beat; alarm = 0.
2. Reply 0x3B00 (-40 °C). Required: temp_data = 0xFB00, alarm = 0. Then reply 0x0AA0. Required: alarm = 1. Then reply 0x0A10 (80.5 °C). Required: alarm stays 1. Then reply 0x0A00. Required: alarm = 0.
3. The core never replies. Required: timeout_err = 1 exactly TIMEOUT_CYC cycles into BUSY; no temp_valid; the next flag arrives on schedule. Send a late reply 0x0320 during WAIT. Required: dropped. Assert err_clr. Required: timeout_err = 0.
4. Reply 0x8320. Required: fmt_err = 1, no temp_valid, temp_data holds its previous value. Assert err_clr and a new fmt error in the same cycle. Required: fmt_err stays 1.
5. Pulse req three times during BUSY. Required: exactly one extra read_temp_flag, issued on entry to WAIT. Pulse req in WAIT 40 cycles after a trigger. Required: a flag on the next cycle and the period counter restarts.
6. Drop enable during BUSY. Required: the transaction completes (temp_valid fires), then IDLE with no further flags. Assert rst during BUSY. Required: all outputs are 0 on the next cycle and a subsequent core reply produces no temp_valid.

Source files
------------

// File: rtl/adt7301_pkg.sv
// Shared types and helpers for the ADT7301 read scheduler.
// Temperature format: 14-bit two's complement in bits [13:0], 31.25 m°C per LSB.
package adt7301_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, TRIG, BUSY} state_e;

  localparam int  TEMP_W      = 14;
  localparam int  RAW_W       = 16;
  localparam real TEMP_LSB_MC = 31.25;

  function automatic logic signed [RAW_W-1:0] raw_to_temp(input logic [RAW_W-1:0] raw);
    return {{(RAW_W-TEMP_W){raw[TEMP_W-1]}}, raw[TEMP_W-1:0]};
  endfunction

endpackage

// File: rtl/adt7301_tick_gen.sv
// Trigger-to-trigger period counter for the ADT7301 scheduler.
// The expire output stays high once the period has elapsed, until the next clear.
module adt7301_tick_gen #(
  parameter int PERIOD_CYC = 12_500_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW   = $clog2(PERIOD_CYC);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating at LAST lets an expiry during a busy read survive until WAIT sees it
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/adt7301_sched.sv
// Read scheduler and result handler for the ADT7301 SPI core: periodic/host
// triggered reads, timeout, format check, sign extension and hysteresis alarm.
module adt7301_sched
  import adt7301_pkg::*;
#(
  parameter int                       PERIOD_CYC  = 12_500_000,
  parameter int                       TIMEOUT_CYC = 4096,
  parameter logic signed [TEMP_W-1:0] ALARM_HI    = 14'sd2720,
  parameter logic signed [TEMP_W-1:0] ALARM_LO    = 14'sd2560
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             req_i,
  input  logic             err_clr_i,
  output logic             read_temp_flag_o,
  input  logic             core_tvalid_i,
  output logic             core_tready_o,
  input  logic [RAW_W-1:0] core_tdata_i,
  output logic             temp_valid_o,
  output logic [RAW_W-1:0] temp_data_o,
  output logic             alarm_o,
  output logic             busy_o,
  output logic             timeout_err_o,
  output logic             fmt_err_o
);

  localparam int                      TW      = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]           TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic signed [RAW_W-1:0] HI_EXT  = RAW_W'(ALARM_HI);
  localparam logic signed [RAW_W-1:0] LO_EXT  = RAW_W'(ALARM_LO);

  state_e                  state_q, state_d;
  logic                    pend_q, pend_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic                    tready_q;
  logic                    tv_q, tv_d;
  logic [RAW_W-1:0]        tdata_q, tdata_d;
  logic                    alarm_q, alarm_d;
  logic                    to_err_q, to_err_d;
  logic                    fmt_err_q, fmt_err_d;
  logic                    tick_clr, tick_expire, beat;
  logic signed [RAW_W-1:0] temp_new;

  assign beat     = core_tvalid_i & tready_q;
  assign temp_new = raw_to_temp(core_tdata_i);
  assign tick_clr = (state_d == TRIG) || (state_q == IDLE);

  adt7301_tick_gen #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tick_clr),
    .en_i     (state_q != IDLE),
    .expire_o (tick_expire)
  );

  // Error clear is applied first so a same-cycle set event overrides it
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    tcnt_d    = tcnt_q;
    tv_d      = 1'b0;
    tdata_d   = tdata_q;
    alarm_d   = alarm_q;
    to_err_d  = to_err_q & ~err_clr_i;
    fmt_err_d = fmt_err_q & ~err_clr_i;
    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (enable_i) state_d = TRIG;
      end
      WAIT: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (tick_expire || req_i || pend_q) begin
          state_d = TRIG;
          pend_d  = 1'b0;
        end
      end
      TRIG: begin
        state_d = BUSY;
        tcnt_d  = '0;
        if (req_i) pend_d = 1'b1;
      end
      BUSY: begin
        if (req_i) pend_d = 1'b1;
        tcnt_d = tcnt_q + 1'b1;
        if (beat) begin
          state_d = enable_i ? WAIT : IDLE;
          if (core_tdata_i[RAW_W-1:TEMP_W] != '0) begin
            fmt_err_d = 1'b1;
          end else begin
            tdata_d = temp_new;
            tv_d    = 1'b1;
            if (temp_new >= HI_EXT) begin
              alarm_d = 1'b1;
            end else if (temp_new <= LO_EXT) begin
              alarm_d = 1'b0;
            end
          end
        end else if (tcnt_q == TO_LAST) begin
          state_d  = enable_i ? WAIT : IDLE;
          to_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      tcnt_q    <= '0;
      tready_q  <= 1'b0;
      tv_q      <= 1'b0;
      tdata_q   <= '0;
      alarm_q   <= 1'b0;
      to_err_q  <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      tcnt_q    <= tcnt_d;
      tready_q  <= 1'b1;
      tv_q      <= tv_d;
      tdata_q   <= tdata_d;
      alarm_q   <= alarm_d;
      to_err_q  <= to_err_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  assign read_temp_flag_o = (state_q == TRIG);
  assign busy_o           = (state_q == BUSY);
  assign core_tready_o    = tready_q;
  assign temp_valid_o     = tv_q;
  assign temp_data_o      = tdata_q;
  assign alarm_o          = alarm_q;
  assign timeout_err_o    = to_err_q;
  assign fmt_err_o        = fmt_err_q;

endmodule

// File: tb/tb_adt7301_sched.sv
// Directed self-checking bench for adt7301_sched with a short period (100)
// and timeout (20); the bench plays the SPI core by driving the result stream.
module tb_adt7301_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        req = 1'b0;
  logic        err_clr = 1'b0;
  logic        read_temp_flag;
  logic        core_tvalid = 1'b0;
  logic        core_tready;
  logic [15:0] core_tdata = 16'h0000;
  logic        temp_valid;
  logic [15:0] temp_data;
  logic        alarm;
  logic        busy;
  logic        timeout_err;
  logic        fmt_err;

  int testsRun  = 0;
  int failCount = 0;

  adt7301_sched #(
    .PERIOD_CYC  (100),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_i         (enable),
    .req_i            (req),
    .err_clr_i        (err_clr),
    .read_temp_flag_o (read_temp_flag),
    .core_tvalid_i    (core_tvalid),
    .core_tready_o    (core_tready),
    .core_tdata_i     (core_tdata),
    .temp_valid_o     (temp_valid),
    .temp_data_o      (temp_data),
    .alarm_o          (alarm),
    .busy_o           (busy),
    .timeout_err_o    (timeout_err),
    .fmt_err_o        (fmt_err)
  );

  always #4 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a flag cycle: the core beat is accepted on the edge `delay` cycles later
  task automatic applyStimulus(input logic [15:0] data, input int delay, input logic clr);
    repeat (delay - 1) step();
    core_tvalid = 1'b1;
    core_tdata  = data;
    err_clr     = clr;
    step();
    core_tvalid = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic waitFlag(input int maxCyc, output int n);
    int k = 0;
    do begin
      step();
      k++;
    end while (!read_temp_flag && k < maxCyc);
    n = read_temp_flag ? k : -1;
  endtask

  initial begin
    int n;
    int flags;
    logic tvSeen;

    // Reset state
    step();
    step();
    checkOutput("rst_tready", core_tready, 0);
    checkOutput("rst_flag",   read_temp_flag, 0);
    checkOutput("rst_busy",   busy, 0);
    checkOutput("rst_tvalid", temp_valid, 0);
    checkOutput("rst_tdata",  temp_data, 0);
    checkOutput("rst_alarm",  alarm, 0);
    checkOutput("rst_toerr",  timeout_err, 0);
    checkOutput("rst_fmterr", fmt_err, 0);
    rst = 1'b0;
    step();
    checkOutput("idle_tready", core_tready, 1);
    checkOutput("idle_flag",   read_temp_flag, 0);

    // 1: immediate first read, then periodic reads
    enable = 1'b1;
    step();
    checkOutput("first_flag", read_temp_flag, 1);
    applyStimulus(16'h0320, 5, 1'b0);
    checkOutput("t1_tvalid", temp_valid, 1);
    checkOutput("t1_tdata",  temp_data, 16'h0320);
    checkOutput("t1_alarm",  alarm, 0);
    checkOutput("t1_busy",   busy, 0);
    step();
    checkOutput("t1_tvalid_1cyc", temp_valid, 0);
    waitFlag(200, n);
    checkOutput("t1_period_a", n, 94);
    applyStimulus(16'h0320, 5, 1'b0);
    checkOutput("t1_tvalid_b", temp_valid, 1);
    checkOutput("t1_tdata_b",  temp_data, 16'h0320);
    waitFlag(200, n);
    checkOutput("t1_period_b", n, 95);

    // 2: negative value and alarm hysteresis
    applyStimulus(16'h3B00, 5, 1'b0);
    checkOutput("t2_neg_tdata", temp_data, 16'hFB00);
    checkOutput("t2_neg_alarm", alarm, 0);
    waitFlag(200, n);
    applyStimulus(16'h0AA0, 5, 1'b0);
    checkOutput("t2_hi_alarm", alarm, 1);
    waitFlag(200, n);
    applyStimulus(16'h0A10, 5, 1'b0);
    checkOutput("t2_mid_tdata", temp_data, 16'h0A10);
    checkOutput("t2_mid_alarm", alarm, 1);
    waitFlag(200, n);
    applyStimulus(16'h0A00, 5, 1'b0);
    checkOutput("t2_lo_alarm", alarm, 0);
    waitFlag(200, n);
    checkOutput("t2_period", n, 95);

    // 3: no reply, timeout, late reply dropped, error clear
    tvSeen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      tvSeen |= temp_valid;
    end
    checkOutput("t3_no_err_early", timeout_err, 0);
    checkOutput("t3_busy_early",   busy, 1);
    step();
    tvSeen |= temp_valid;
    checkOutput("t3_timeout_err", timeout_err, 1);
    checkOutput("t3_busy_after",  busy, 0);
    checkOutput("t3_no_tvalid",   tvSeen, 0);
    core_tvalid = 1'b1;
    core_tdata  = 16'h0320;
    step();
    core_tvalid = 1'b0;
    checkOutput("t3_late_tvalid", temp_valid, 0);
    checkOutput("t3_late_fmt",    fmt_err, 0);
    checkOutput("t3_late_tdata",  temp_data, 16'h0A00);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("t3_err_clr", timeout_err, 0);
    waitFlag(200, n);
    checkOutput("t3_period", n, 77);

    // 4: format error, and set wins over a same-cycle clear
    applyStimulus(16'h8320, 5, 1'b0);
    checkOutput("t4_fmt_err", fmt_err, 1);
    checkOutput("t4_tvalid",  temp_valid, 0);
    checkOutput("t4_tdata",   temp_data, 16'h0A00);
    waitFlag(200, n);
    applyStimulus(16'h8320, 5, 1'b1);
    checkOutput("t4_set_wins", fmt_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("t4_fmt_clr", fmt_err, 0);
    waitFlag(200, n);
    checkOutput("t4_period", n, 94);

    // 5: three req pulses in BUSY collapse into one extra read
    step();
    req = 1'b1; step(); req = 1'b0;
    step();
    req = 1'b1; step(); req = 1'b0;
    step();
    req = 1'b1; step(); req = 1'b0;
    core_tvalid = 1'b1;
    core_tdata  = 16'h0320;
    step();
    core_tvalid = 1'b0;
    checkOutput("t5_tvalid",    temp_valid, 1);
    checkOutput("t5_flag_wait", read_temp_flag, 0);
    step();
    checkOutput("t5_pend_flag", read_temp_flag, 1);
    applyStimulus(16'h0320, 5, 1'b0);
    waitFlag(200, n);
    checkOutput("t5_one_extra", n, 95);
    applyStimulus(16'h0320, 5, 1'b0);
    repeat (35) step();
    checkOutput("t5_req_before", read_temp_flag, 0);
    req = 1'b1;
    step();
    req = 1'b0;
    checkOutput("t5_req_flag", read_temp_flag, 1);
    applyStimulus(16'h0320, 5, 1'b0);
    waitFlag(200, n);
    checkOutput("t5_restart", n, 95);

    // 6: disable during BUSY completes the read; reset during BUSY
    step();
    enable = 1'b0;
    applyStimulus(16'h0100, 4, 1'b0);
    checkOutput("t6_tvalid", temp_valid, 1);
    checkOutput("t6_tdata",  temp_data, 16'h0100);
    checkOutput("t6_busy",   busy, 0);
    flags = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (read_temp_flag) flags++;
    end
    checkOutput("t6_no_flags", flags, 0);
    enable = 1'b1;
    step();
    checkOutput("t6_reen_flag", read_temp_flag, 1);
    step();
    checkOutput("t6_busy_pre_rst", busy, 1);
    rst    = 1'b1;
    enable = 1'b0;
    step();
    checkOutput("t6_rst_busy",   busy, 0);
    checkOutput("t6_rst_tready", core_tready, 0);
    checkOutput("t6_rst_flag",   read_temp_flag, 0);
    checkOutput("t6_rst_tdata",  temp_data, 0);
    checkOutput("t6_rst_tvalid", temp_valid, 0);
    checkOutput("t6_rst_alarm",  alarm, 0);
    checkOutput("t6_rst_errs",   {timeout_err, fmt_err}, 0);
    rst         = 1'b0;
    core_tvalid = 1'b1;
    core_tdata  = 16'h0320;
    step();
    checkOutput("t6_post_tv_a", temp_valid, 0);
    step();
    core_tvalid = 1'b0;
    checkOutput("t6_post_tv_b", temp_valid, 0);
    step();
    checkOutput("t6_post_tv_c",  temp_valid, 0);
    checkOutput("t6_post_tdata", temp_data, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
